// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one UART transmitter between
// NUM_REQ requesters. Each transfer walks IDLE -> START -> BUSY -> RELEASE.
// Optional build macro UART_ARB_TIMEOUT_EN adds a watchdog that forces
// RELEASE (with timeout_err) when tx_done never arrives within TIMEOUT_CYC
// BUSY cycles; without it BUSY waits for tx_done indefinitely.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   ack,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 tx_data_avail,
  output logic [7:0]           tx_data_byte,
  input  logic                 tx_active,
  input  logic                 tx_done,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("uart_tx_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYC at least 1");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    START   = 2'd1,
    BUSY    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] owner;
  logic [PTR_W-1:0] winner;
  logic             win_valid;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] tmo_cnt;
  logic             tmo_flag;
  logic             timed_out;
`endif

  // Round-robin search: first requester with req high, starting at rr_ptr and wrapping
  always_comb begin
    int idx;
    winner    = '0;
    win_valid = 1'b0;
    idx       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!win_valid && req[idx]) begin
        win_valid = 1'b1;
        winner    = idx[PTR_W-1:0];
      end
    end
  end

  // Next-state logic; no grant while the transmitter is still busy from elsewhere
  always_comb begin
    state_nxt = state;
`ifdef UART_ARB_TIMEOUT_EN
    timed_out = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (win_valid && !tx_active) begin
          state_nxt = START;
        end
      end
      START: begin
        state_nxt = BUSY;
      end
      BUSY: begin
        if (tx_done) begin
          state_nxt = RELEASE;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
          state_nxt = RELEASE;
          timed_out = 1'b1;
        end
`endif
      end
      RELEASE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Latch the winner, its byte and grant at arbitration; clear grant and advance rr_ptr at release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant        <= '0;
      owner        <= '0;
      rr_ptr       <= '0;
      tx_data_byte <= 8'h00;
    end else begin
      if (state == IDLE && state_nxt == START) begin
        grant        <= NUM_REQ'(1) << winner;
        owner        <= winner;
        tx_data_byte <= req_data[int'(winner)*8 +: 8];
      end else if (state == RELEASE) begin
        grant  <= '0;
        rr_ptr <= (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
      end
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  // Watchdog: cleared on entry to BUSY, counts each BUSY cycle, flags a forced release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt  <= '0;
      tmo_flag <= 1'b0;
    end else begin
      tmo_flag <= timed_out;
      if (state == START) begin
        tmo_cnt <= '0;
      end else if (state == BUSY) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end

  assign timeout_err = tmo_flag;
`else
  assign timeout_err = 1'b0;
`endif

  assign tx_data_avail = (state == START);
  assign busy          = (state != IDLE);
  assign ack           = (state == RELEASE) ? grant : '0;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: a table of single-request vectors plus
// hand-written sequences (contention, withdraw, tx_active hold-off, stuck
// transmitter / timeout, reset mid-transfer). Strobed bytes are checked
// against a scoreboard queue filled when each request is driven.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = 4'b0000;
  logic [31:0] req_data = {8'hD3, 8'hC2, 8'hB1, 8'hA5};
  logic [3:0]  ack;
  logic [3:0]  grant;
  logic        tx_data_avail;
  logic [7:0]  tx_data_byte;
  logic        tx_active = 1'b0;
  logic        tx_done = 1'b0;
  logic        busy;
  logic        timeout_err;

  typedef struct {
    logic [3:0] req;
    logic [3:0] exp_grant;
    logic [7:0] exp_byte;
    int         frame;
  } vec_t;

  typedef struct {
    logic [7:0] b;
    logic [3:0] g;
  } sb_t;

  vec_t vecs[8];
  sb_t  sb_q[$];
  sb_t  sb_e;
  int   nvec = 0;
  int   nerr = 0;

  uart_tx_arbiter #(
    .NUM_REQ(4),
    .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .req_data(req_data),
    .ack(ack),
    .grant(grant),
    .tx_data_avail(tx_data_avail),
    .tx_data_byte(tx_data_byte),
    .tx_active(tx_active),
    .tx_done(tx_done),
    .busy(busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a request pattern and record the strobe it should produce
  task automatic applyStimulus(input logic [3:0] r, input logic [7:0] b, input logic [3:0] g);
    req = r;
    sb_q.push_back('{b, g});
  endtask

  // Act as the transmitter for one transfer; mode 0 drops req at ack,
  // mode 1 keeps req held, mode 2 drops req while BUSY
  task automatic serve(input int frame, input logic [3:0] exp_ack, input int mode);
    int k;
    k = 0;
    while (!tx_data_avail && k < 50) begin
      step();
      k++;
    end
    if (!tx_data_avail) begin
      nvec++;
      nerr++;
      $display("[TB] FAIL avail_wait: tx_data_avail 0 after 50 cycles, expected 1");
      return;
    end
    tx_active = 1'b1;
    step();
    if (mode == 2) req = 4'b0000;
    checkOutput("busy_in_busy", 8'(busy), 8'h01);
    repeat (frame - 1) step();
    checkOutput("ack_before_done", 8'(ack), 8'h00);
    tx_done = 1'b1;
    step();
    tx_done   = 1'b0;
    tx_active = 1'b0;
    checkOutput("ack", 8'(ack), 8'(exp_ack));
    checkOutput("timeout_err_clean", 8'(timeout_err), 8'h00);
    if (mode != 1) req = 4'b0000;
    step();
    checkOutput("grant_cleared", 8'(grant), 8'h00);
    checkOutput("ack_cleared", 8'(ack), 8'h00);
  endtask

  // Monitor: structural invariants and scoreboard comparison at each start strobe
  always @(negedge clk) begin
    if (rst) begin
      checkOutput("grant_onehot0", 8'($onehot0(grant)), 8'h01);
      checkOutput("ack_onehot0", 8'($onehot0(ack)), 8'h01);
      if (tx_data_avail) begin
        if (sb_q.size() == 0) begin
          nvec++;
          nerr++;
          $display("[TB] FAIL sb_unexpected: strobe with byte 0x%0h, expected no strobe", tx_data_byte);
        end else begin
          sb_e = sb_q.pop_front();
          checkOutput("sb_byte", tx_data_byte, sb_e.b);
          checkOutput("sb_grant", 8'(grant), 8'(sb_e.g));
        end
      end
    end
  end

  initial begin
    vecs[0] = '{4'b0001, 4'b0001, 8'hA5, 2};
    vecs[1] = '{4'b0001, 4'b0001, 8'hA5, 1};
    vecs[2] = '{4'b0110, 4'b0010, 8'hB1, 3};
    vecs[3] = '{4'b0110, 4'b0100, 8'hC2, 2};
    vecs[4] = '{4'b0101, 4'b0001, 8'hA5, 4};
    vecs[5] = '{4'b1000, 4'b1000, 8'hD3, 1};
    vecs[6] = '{4'b1001, 4'b0001, 8'hA5, 5};
    vecs[7] = '{4'b1010, 4'b0010, 8'hB1, 2};

    // Reset values
    #1;
    checkOutput("rst_grant", 8'(grant), 8'h00);
    checkOutput("rst_byte", tx_data_byte, 8'h00);
    checkOutput("rst_busy", 8'(busy), 8'h00);
    step();
    step();
    rst = 1'b1;
    step();

    // Table: single-cycle arbitration latency and round-robin order
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].req, vecs[i].exp_byte, vecs[i].exp_grant);
      step();
      checkOutput($sformatf("v%0d_avail", i), 8'(tx_data_avail), 8'h01);
      checkOutput($sformatf("v%0d_grant", i), 8'(grant), 8'(vecs[i].exp_grant));
      checkOutput($sformatf("v%0d_byte", i), tx_data_byte, vecs[i].exp_byte);
      serve(vecs[i].frame, vecs[i].exp_grant, 0);
    end

    // Contention from a fresh reset: 10,11,12,13,10
    rst = 1'b0;
    step();
    rst = 1'b1;
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    applyStimulus(4'b1111, 8'h10, 4'b0001);
    sb_q.push_back('{8'h11, 4'b0010});
    sb_q.push_back('{8'h12, 4'b0100});
    sb_q.push_back('{8'h13, 4'b1000});
    sb_q.push_back('{8'h10, 4'b0001});
    serve(3, 4'b0001, 1);
    serve(3, 4'b0010, 1);
    serve(2, 4'b0100, 1);
    serve(3, 4'b1000, 1);
    serve(2, 4'b0001, 0);

    // Withdraw: owner drops req in BUSY, then next grant follows rr_ptr
    req_data = {8'hD3, 8'hC2, 8'hB1, 8'hA5};
    applyStimulus(4'b0010, 8'hB1, 4'b0010);
    serve(3, 4'b0010, 2);
    applyStimulus(4'b0011, 8'hA5, 4'b0001);
    serve(2, 4'b0001, 0);

    // tx_active high in IDLE holds off the grant
    tx_active = 1'b1;
    req = 4'b0100;
    repeat (3) begin
      step();
      checkOutput("hold_grant", 8'(grant), 8'h00);
      checkOutput("hold_avail", 8'(tx_data_avail), 8'h00);
    end
    applyStimulus(4'b0100, 8'hC2, 4'b0100);
    tx_active = 1'b0;
    step();
    checkOutput("hold_release_avail", 8'(tx_data_avail), 8'h01);
    serve(2, 4'b0100, 0);

    // tx_done while idle is ignored
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    checkOutput("idle_done_ack", 8'(ack), 8'h00);
    checkOutput("idle_done_busy", 8'(busy), 8'h00);

    // Stuck transmitter
    applyStimulus(4'b0001, 8'hA5, 4'b0001);
    step();
    checkOutput("stuck_avail", 8'(tx_data_avail), 8'h01);
    step();
    req = 4'b0000;
`ifdef UART_ARB_TIMEOUT_EN
    repeat (15) step();
    checkOutput("tmo_early_ack", 8'(ack), 8'h00);
    checkOutput("tmo_early_err", 8'(timeout_err), 8'h00);
    step();
    checkOutput("tmo_ack", 8'(ack), 8'h01);
    checkOutput("tmo_err", 8'(timeout_err), 8'h01);
    step();
    checkOutput("tmo_err_clear", 8'(timeout_err), 8'h00);
    checkOutput("tmo_idle", 8'(busy), 8'h00);
    applyStimulus(4'b0010, 8'hB1, 4'b0010);
    step();
    checkOutput("rst_seq_avail", 8'(tx_data_avail), 8'h01);
    tx_active = 1'b1;
    step();
    step();
`else
    repeat (40) step();
    checkOutput("stuck_busy", 8'(busy), 8'h01);
    checkOutput("stuck_ack", 8'(ack), 8'h00);
    checkOutput("stuck_grant", 8'(grant), 8'h01);
    checkOutput("stuck_err", 8'(timeout_err), 8'h00);
`endif

    // Reset mid-BUSY: immediate reset values, no ack, search restarts at 0
    checkOutput("pre_rst_busy", 8'(busy), 8'h01);
    rst = 1'b0;
    #1;
    checkOutput("mid_rst_grant", 8'(grant), 8'h00);
    checkOutput("mid_rst_ack", 8'(ack), 8'h00);
    checkOutput("mid_rst_avail", 8'(tx_data_avail), 8'h00);
    checkOutput("mid_rst_byte", tx_data_byte, 8'h00);
    checkOutput("mid_rst_busy", 8'(busy), 8'h00);
    checkOutput("mid_rst_err", 8'(timeout_err), 8'h00);
    tx_active = 1'b0;
    req = 4'b0000;
    step();
    rst = 1'b1;
    step();
    applyStimulus(4'b1000, 8'hD3, 4'b1000);
    step();
    checkOutput("post_rst_grant", 8'(grant), 8'h08);
    serve(2, 4'b1000, 0);

    repeat (3) step();
    checkOutput("sb_drained", 8'(sb_q.size()), 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, the number of requesters (2..8).
REQ-002 The block SHALL have parameter TIMEOUT_CYC, default 4096, the maximum clk cycles allowed from grant to tx_done (used only with UART_ARB_TIMEOUT_EN).
REQ-003 Port clk  input  1  the single system clock; all logic is rising-edge.
REQ-004 Port rst  input  1  asynchronous, active-low reset.
REQ-005 Port req  input  NUM_REQ  per-requester transmit request, level, held until ack.
REQ-006 Port req_data  input  8*NUM_REQ  byte of requester i on bits [8i+7:8i].
REQ-007 Port ack  output  NUM_REQ  one-cycle pulse to the owner when its byte has finished.
REQ-008 Port grant  output  NUM_REQ  one-hot current owner; all zero when idle.
REQ-009 Port tx_data_avail  output  1  one-cycle start strobe to the UART transmitter.
REQ-010 Port tx_data_byte  output  8  latched byte to the transmitter, stable from strobe until ack.
REQ-011 Port tx_active  input  1  transmitter busy indication.
REQ-012 Port tx_done  input  1  transmitter one-cycle completion pulse.
REQ-013 Port busy  output  1  high in any state other than IDLE.
REQ-014 Port timeout_err  output  1  one-cycle pulse coincident with ack on a timed-out transfer.

Function
REQ-015 The FSM SHALL have states IDLE, START, BUSY and RELEASE.
REQ-016 IDLE: when any req bit is high, the block SHALL select one winner, latch its byte into tx_data_byte, set grant, and move to START on the next edge.
REQ-017 Selection SHALL be round-robin: search starts at index rr_ptr and wraps from NUM_REQ-1 to 0; the first requester with req high wins.
REQ-018 After each RELEASE, rr_ptr SHALL be set to (winner+1) mod NUM_REQ.
REQ-019 START: tx_data_avail SHALL be high for exactly this one cycle, then the FSM SHALL enter BUSY.
REQ-020 Latency: req rising in cycle N with the block idle SHALL produce tx_data_avail in cycle N+1.
REQ-021 BUSY: the FSM SHALL wait for tx_done=1, then enter RELEASE; tx_done seen in IDLE or START SHALL be ignored.
REQ-022 RELEASE: ack[winner] SHALL pulse for one cycle, grant SHALL clear, and the FSM SHALL return to IDLE.
REQ-023 Arbitration for the next transfer SHALL occur in IDLE, giving a minimum of 3 cycles from one tx_data_avail to the next beyond the transmitter frame time.
REQ-024 The owner deasserting req after grant SHALL NOT abort the transfer; the byte is already latched and ack is still issued.
REQ-025 req changes by non-owners during START, BUSY or RELEASE SHALL have no effect until IDLE.
REQ-026 If tx_active is already high in IDLE, the block SHALL NOT grant until tx_active is low.
REQ-027 grant SHALL be one-hot or zero in every cycle; ack SHALL never be high for more than one bit.

Reset
REQ-028 While rst=0, asynchronously: state=IDLE, rr_ptr=0, grant=0, ack=0, tx_data_avail=0, tx_data_byte=8'h00, busy=0, timeout_err=0, and the timeout counter=0.
REQ-029 Reset asserted mid-transfer SHALL drop the transfer without ack; the first grant after release SHALL start the search at index 0.

Configuration
REQ-030 With UART_ARB_TIMEOUT_EN defined, a counter SHALL clear on entering BUSY and increment each BUSY cycle; on reaching TIMEOUT_CYC without tx_done, the FSM SHALL go to RELEASE with ack and timeout_err pulsed together.
REQ-031 Without UART_ARB_TIMEOUT_EN, no counter SHALL be built, timeout_err SHALL be tied to 0, and BUSY SHALL wait indefinitely for tx_done.

Verification
REQ-032 Single request: req=4'b0001 with byte 8'hA5 -> tx_data_avail one cycle later, tx_data_byte=8'hA5, grant=4'b0001, ack[0] one cycle after tx_done.
REQ-033 Contention: req=4'b1111 held, bytes 8'h10/11/12/13 -> transmitted in order 10,11,12,13,10, with an ack after each.
REQ-034 Fairness: after requester 2 is served, req=4'b0101 -> requester 0 wins next (search wraps from 3), not requester 2.
REQ-035 Withdraw: the owner drops req in BUSY -> byte still sent, ack still pulses, and the next grant follows rr_ptr.
REQ-036 Timeout (macro on, TIMEOUT_CYC=16): tx_done never asserted -> ack and timeout_err pulse together 16 cycles after entering BUSY; with the macro off, the block stays BUSY.
REQ-037 Reset mid-BUSY -> all outputs at reset values immediately, no ack; after release, req=4'b1000 -> grant=4'b1000.
